vga_scan_ctrl: RTL and testbench

//  Sequences the 25 MHz pixel-enable toggle divider and the VGA raster for the game display.

---
 rtl/vga_scan_if.sv | 50 +++++
 rtl/vga_scan_ctrl.sv | 136 +++++++++++++
 tb/tb_vga_scan_ctrl.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_scan_if.sv
// ============================================================================
// Module   : vga_scan_if
// Purpose  : Control/raster bundle between the scan controller and its users.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface vga_scan_if;
    logic       run_i;
    logic       pix_en_i;
    logic       div_en_o;
    logic       busy_o;
    logic       hsync_o;
    logic       vsync_o;
    logic       video_on_o;
    logic [9:0] x_o;
    logic [9:0] y_o;
    logic       frame_start_o;
    logic       line_end_o;

    modport slave (
        input  run_i,
        input  pix_en_i,
        output div_en_o,
        output busy_o,
        output hsync_o,
        output vsync_o,
        output video_on_o,
        output x_o,
        output y_o,
        output frame_start_o,
        output line_end_o
    );

    modport master (
        output run_i,
        output pix_en_i,
        input  div_en_o,
        input  busy_o,
        input  hsync_o,
        input  vsync_o,
        input  video_on_o,
        input  x_o,
        input  y_o,
        input  frame_start_o,
        input  line_end_o
    );
endinterface

`default_nettype wire

// File: rtl/vga_scan_ctrl.sv
// ============================================================================
// Module   : vga_scan_ctrl
// Purpose  : Pixel-divider sequencing and VGA raster timing with frame-aligned stop.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module vga_scan_ctrl #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic SYNC_POL = 1'b0
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    vga_scan_if.slave   bus
);

    localparam int         H_TOT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int         V_TOT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [9:0] H_LAST = 10'(H_TOT - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOT - 1);
    localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_STOP = 2'd2;

    logic [1:0] state_q, state_d;
    logic [9:0] h_q, h_d, v_q, v_d;
    logic       div_en_q, div_en_d;
    logic       busy_q, busy_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       video_q, video_d;
    logic       fstart_q, fstart_d;
    logic       lend_q, lend_d;

    logic       adv_w, h_wrap_w, v_wrap_w, live_w;

    assign adv_w    = (state_q != S_IDLE) && bus.pix_en_i;
    assign h_wrap_w = adv_w && (h_q == H_LAST);
    assign v_wrap_w = h_wrap_w && (v_q == V_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A stop request is only honoured on the last pixel of the frame.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (bus.run_i) state_d = S_RUN;
            S_RUN:  if (!bus.run_i) state_d = S_STOP;
            S_STOP: begin
                if (bus.run_i) begin
                    state_d = S_RUN;
                end else if (v_wrap_w) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Decode from next-count so registered outputs line up with x_o/y_o.
    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (adv_w) begin
            h_d = h_wrap_w ? 10'd0 : h_q + 10'd1;
            if (h_wrap_w) begin
                v_d = v_wrap_w ? 10'd0 : v_q + 10'd1;
            end
        end
        live_w   = (state_d != S_IDLE);
        div_en_d = live_w;
        busy_d   = live_w;
        hsync_d  = (live_w && h_d >= HS_BEG && h_d <= HS_END) ? SYNC_POL : ~SYNC_POL;
        vsync_d  = (live_w && v_d >= VS_BEG && v_d <= VS_END) ? SYNC_POL : ~SYNC_POL;
        video_d  = live_w && (h_d < H_VIS) && (v_d < V_VIS);
        lend_d   = h_wrap_w;
        fstart_d = ((state_q == S_IDLE) && (state_d == S_RUN)) || (v_wrap_w && live_w);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q      <= 10'd0;
            v_q      <= 10'd0;
            div_en_q <= 1'b0;
            busy_q   <= 1'b0;
            hsync_q  <= ~SYNC_POL;
            vsync_q  <= ~SYNC_POL;
            video_q  <= 1'b0;
            fstart_q <= 1'b0;
            lend_q   <= 1'b0;
        end else begin
            h_q      <= h_d;
            v_q      <= v_d;
            div_en_q <= div_en_d;
            busy_q   <= busy_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            video_q  <= video_d;
            fstart_q <= fstart_d;
            lend_q   <= lend_d;
        end
    end

    assign bus.div_en_o      = div_en_q;
    assign bus.busy_o        = busy_q;
    assign bus.hsync_o       = hsync_q;
    assign bus.vsync_o       = vsync_q;
    assign bus.video_on_o    = video_q;
    assign bus.x_o           = h_q;
    assign bus.y_o           = v_q;
    assign bus.frame_start_o = fstart_q;
    assign bus.line_end_o    = lend_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_scan_ctrl.sv
// ============================================================================
// Module   : tb_vga_scan_ctrl
// Purpose  : Directed bench: full-size raster (u_a) and a reduced raster (u_b).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_vga_scan_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    logic run;
    logic pe_a = 1'b0;
    logic pe_b = 1'b0;

    int errors = 0;
    int checks = 0;

    int n_pix[2], n_hs[2], n_vs[2], n_vo[2], n_le[2], n_fs[2];
    int hs_first[2], hs_last[2], vs_first[2], vs_last[2], y_max[2];
    int a_total;

    vga_scan_if ifa();
    vga_scan_if ifb();

    assign ifa.run_i    = run;
    assign ifb.run_i    = run;
    assign ifa.pix_en_i = pe_a;
    assign ifb.pix_en_i = pe_b;

    vga_scan_ctrl u_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    // Reduced raster: H 16/4/6/6 (32 total), V 12/2/2/4 (20 total).
    vga_scan_ctrl #(
        .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
        .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(4),
        .SYNC_POL(1'b0)
    ) u_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
    );

    always #5 clk = ~clk;

    // Divider model: toggles every clk while enabled, giving a 1-clk pulse every 2nd clk.
    always @(negedge clk) begin
        pe_a = ifa.div_en_o ? ~pe_a : 1'b0;
        pe_b = ifb.div_en_o ? ~pe_b : 1'b0;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clr(input int k);
        n_pix[k] = 0; n_hs[k] = 0; n_vs[k] = 0; n_vo[k] = 0; n_le[k] = 0; n_fs[k] = 0;
        hs_first[k] = -1; hs_last[k] = -1; vs_first[k] = -1; vs_last[k] = -1; y_max[k] = 0;
    endtask

    task automatic upd(input int k, input logic p, input logic hs, input logic vs,
                       input logic vo, input logic le, input logic fs,
                       input logic [9:0] x, input logic [9:0] y);
        if (p) begin
            n_pix[k]++;
            if (k == 0) a_total++;
            if (hs == 1'b0) begin
                n_hs[k]++;
                if (hs_first[k] < 0) hs_first[k] = int'(x);
                hs_last[k] = int'(x);
            end
            if (vs == 1'b0) begin
                n_vs[k]++;
                if (vs_first[k] < 0) vs_first[k] = int'(y);
                vs_last[k] = int'(y);
            end
            if (vo) n_vo[k]++;
            if (int'(y) > y_max[k]) y_max[k] = int'(y);
        end
        if (le) n_le[k]++;
        if (fs) n_fs[k]++;
    endtask

    task automatic adv_clk();
        logic pa, pb;
        @(posedge clk);
        pa = pe_a;
        pb = pe_b;
        #1;
        upd(0, pa, ifa.hsync_o, ifa.vsync_o, ifa.video_on_o, ifa.line_end_o,
            ifa.frame_start_o, ifa.x_o, ifa.y_o);
        upd(1, pb, ifb.hsync_o, ifb.vsync_o, ifb.video_on_o, ifb.line_end_o,
            ifb.frame_start_o, ifb.x_o, ifb.y_o);
    endtask

    task automatic run_until(input int k, input int n);
        int start = n_pix[k];
        int guard = 0;
        while ((n_pix[k] - start) < n && guard < 4 * n + 20) begin
            adv_clk();
            guard++;
        end
        chk("pix_budget", n_pix[k] - start, n);
    endtask

    initial begin
        int pix_hold;
        rst_n = 1'b0;
        run   = 1'b0;
        a_total = 0;
        clr(0);
        clr(1);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_div_en", ifa.div_en_o, 0);
        chk("rst_busy", ifa.busy_o, 0);
        chk("rst_hsync", ifa.hsync_o, 1);
        chk("rst_vsync", ifa.vsync_o, 1);
        chk("rst_video", ifa.video_on_o, 0);
        chk("rst_x", ifa.x_o, 0);
        chk("rst_y", ifa.y_o, 0);
        chk("rst_fs", ifa.frame_start_o, 0);
        chk("rst_le", ifa.line_end_o, 0);
        chk("rst_b_busy", ifb.busy_o, 0);

        // Start: one edge IDLE->RUN, counters held at origin.
        @(negedge clk);
        rst_n = 1'b1;
        run   = 1'b1;
        adv_clk();
        chk("start_div_en", ifa.div_en_o, 1);
        chk("start_busy", ifa.busy_o, 1);
        chk("start_fs", ifa.frame_start_o, 1);
        chk("start_x", ifa.x_o, 0);
        chk("start_y", ifa.y_o, 0);
        chk("start_b_fs", ifb.frame_start_o, 1);
        clr(0);
        clr(1);
        a_total = 0;
        adv_clk();
        chk("fs_one_clk", ifa.frame_start_o, 0);
        chk("first_pix_x", ifa.x_o, 1);

        // Reduced raster: one full frame.
        run_until(1, 639);
        chk("b_wrap_x", ifb.x_o, 0);
        chk("b_wrap_y", ifb.y_o, 0);
        chk("b_wrap_fs", ifb.frame_start_o, 1);
        chk("b_fs_count", n_fs[1], 1);
        chk("b_le_count", n_le[1], 20);
        chk("b_vs_pix", n_vs[1], 64);
        chk("b_vs_first", vs_first[1], 14);
        chk("b_vs_last", vs_last[1], 15);
        chk("b_y_max", y_max[1], 19);
        chk("b_video_pix", n_vo[1], 192);
        chk("b_hs_pix", n_hs[1], 120);
        clr(1);

        // Full-size raster: one complete line.
        run_until(0, 160);
        chk("a_line_x", ifa.x_o, 0);
        chk("a_line_y", ifa.y_o, 1);
        chk("a_hs_pix", n_hs[0], 96);
        chk("a_hs_first", hs_first[0], 656);
        chk("a_hs_last", hs_last[0], 751);
        chk("a_video_pix", n_vo[0], 640);
        chk("a_le_count", n_le[0], 1);
        chk("a_fs_count", n_fs[0], 0);

        // Stop request mid-frame on reduced raster: drains to frame end.
        run_until(1, 69);
        chk("b_stop_at_x", ifb.x_o, 5);
        chk("b_stop_at_y", ifb.y_o, 7);
        run = 1'b0;
        run_until(1, 410);
        chk("b_last_x", ifb.x_o, 31);
        chk("b_last_y", ifb.y_o, 19);
        chk("b_drain_busy", ifb.busy_o, 1);
        chk("b_drain_div", ifb.div_en_o, 1);
        run_until(1, 1);
        chk("b_idle_busy", ifb.busy_o, 0);
        chk("b_idle_div", ifb.div_en_o, 0);
        chk("b_idle_x", ifb.x_o, 0);
        chk("b_idle_y", ifb.y_o, 0);
        chk("b_idle_hsync", ifb.hsync_o, 1);
        chk("b_idle_vsync", ifb.vsync_o, 1);
        chk("b_idle_video", ifb.video_on_o, 0);
        pix_hold = n_pix[1];
        repeat (4) adv_clk();
        chk("b_idle_no_pix", n_pix[1] - pix_hold, 0);
        chk("b_idle_hold_x", ifb.x_o, 0);
        chk("a_stopping_busy", ifa.busy_o, 1);

        // Re-raise run: u_a resumes without disturbance, u_b restarts from origin.
        clr(0);
        run = 1'b1;
        adv_clk();
        chk("a_resume_fs", ifa.frame_start_o, 0);
        chk("a_resume_busy", ifa.busy_o, 1);
        chk("b_restart_fs", ifb.frame_start_o, 1);
        chk("b_restart_div", ifb.div_en_o, 1);
        chk("b_restart_x", ifb.x_o, 0);
        clr(1);
        run_until(0, 100);
        chk("a_cont_x", ifa.x_o, a_total % 800);
        chk("a_cont_y", ifa.y_o, (a_total / 800) % 525);
        chk("a_no_extra_fs", n_fs[0], 0);
        chk("a_cont_busy", ifa.busy_o, 1);

        // Asynchronous reset between clock edges.
        run_until(1, 50);
        chk("b_pre_rst_x", ifb.x_o, n_pix[1] % 32);
        chk("b_pre_rst_y", ifb.y_o, (n_pix[1] / 32) % 20);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_b_busy", ifb.busy_o, 0);
        chk("arst_b_div", ifb.div_en_o, 0);
        chk("arst_b_x", ifb.x_o, 0);
        chk("arst_b_y", ifb.y_o, 0);
        chk("arst_b_hsync", ifb.hsync_o, 1);
        chk("arst_a_x", ifa.x_o, 0);
        chk("arst_a_busy", ifa.busy_o, 0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        adv_clk();
        chk("rest_b_fs", ifb.frame_start_o, 1);
        chk("rest_b_x", ifb.x_o, 0);
        chk("rest_b_y", ifb.y_o, 0);
        chk("rest_a_fs", ifa.frame_start_o, 1);
        run_until(1, 1);
        chk("rest_b_x1", ifb.x_o, 1);
        chk("rest_b_y1", ifb.y_o, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
